// File: rtl/button_debouncer.sv
// button_debouncer
//   Turns a raw, bouncing, asynchronous push-button pad into a clean debounced
//   level plus one-cycle press / release / long-press event pulses. The level
//   (or the rise pulse) is intended to drive the T input of the downstream
//   edge-triggered toggle stage, so one physical press gives one toggle.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous reset, active low
//   btn_raw    in   raw asynchronous button pad
//   btn_level  out  debounced pressed level (1 = pressed), registered
//   btn_rise   out  one-cycle pulse when a press is accepted
//   btn_fall   out  one-cycle pulse when a release is accepted
//   btn_long   out  one-cycle pulse once a press has been held LONG_CYCLES
module button_debouncer #(
    parameter int CNT_WIDTH       = 24,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 10000000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall,
    output logic btn_long
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HIGH = 2'd1,
        PRESSED   = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] DEB_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LONG_MAX  = CNT_WIDTH'(LONG_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    logic                 w_pad;
    logic                 w_s;
    logic                 r_sync_p0;
    logic                 r_sync_p1;

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic [CNT_WIDTH-1:0] r_hold;
    logic [CNT_WIDTH-1:0] w_hold_next;
    logic                 w_level_next;
    logic                 w_rise_next;
    logic                 w_fall_next;
    logic                 w_long_next;

    // Polarity is folded in before the synchronizer so everything downstream
    // sees 1 = pressed.
    assign w_pad = btn_raw ^ ACTIVE_LOW;

    // Stage p0 -> p1: two-flop synchronizer for the asynchronous pad
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
        end else begin
            r_sync_p0 <= w_pad;
            r_sync_p1 <= r_sync_p0;
        end
    end

    assign w_s = r_sync_p1;

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_hold    <= '0;
            btn_level <= 1'b0;
            btn_rise  <= 1'b0;
            btn_fall  <= 1'b0;
            btn_long  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_hold    <= w_hold_next;
            btn_level <= w_level_next;
            btn_rise  <= w_rise_next;
            btn_fall  <= w_fall_next;
            btn_long  <= w_long_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_s) w_state_next = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (!w_s)                 w_state_next = IDLE;
                else if (r_cnt == DEB_LAST) w_state_next = PRESSED;
            end
            PRESSED: begin
                if (!w_s) w_state_next = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (w_s)                  w_state_next = PRESSED;
                else if (r_cnt == DEB_LAST) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Counter and output-next logic. The IDLE/WAIT entries preload cnt = 1 so
    // the edge that first sees the new level counts as the first stable cycle.
    always_comb begin
        w_cnt_next   = r_cnt;
        w_hold_next  = r_hold;
        w_level_next = btn_level;
        w_rise_next  = 1'b0;
        w_fall_next  = 1'b0;
        w_long_next  = 1'b0;
        case (r_state)
            IDLE: begin
                w_level_next = 1'b0;
                w_cnt_next   = w_s ? CNT_ONE : '0;
            end
            WAIT_HIGH: begin
                if (!w_s) begin
                    w_cnt_next = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_cnt_next   = '0;
                    w_hold_next  = '0;
                    w_level_next = 1'b1;
                    w_rise_next  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!w_s) begin
                    w_cnt_next = CNT_ONE;
                end else if (r_hold == LONG_LAST) begin
                    // Single crossing into saturation: the only place btn_long fires
                    w_hold_next = LONG_MAX;
                    w_long_next = 1'b1;
                end else if (r_hold != LONG_MAX) begin
                    w_hold_next = r_hold + CNT_ONE;
                end
            end
            WAIT_LOW: begin
                // hold is deliberately left untouched here so a release glitch
                // does not restart the long-press timer
                if (w_s) begin
                    w_cnt_next = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_cnt_next   = '0;
                    w_hold_next  = '0;
                    w_level_next = 1'b0;
                    w_fall_next  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_hold_next  = '0;
                w_level_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer
//   Scenario-driven bench for button_debouncer with DEBOUNCE_CYCLES=4 and
//   LONG_CYCLES=20. Instance u_dut0 uses active-high polarity and is tracked by
//   a window-based behavioural model; u_dut1 is the active-low variant.
module tb_button_debouncer;

    localparam int DEB   = 4;
    localparam int LONGC = 20;

    logic clk;
    logic rst;
    logic raw0, raw1;
    logic lvl0, rise0, fall0, long0;
    logic lvl1, rise1, fall1, long1;

    int total = 0;
    int bad   = 0;

    // Behavioural model state: raw samples in flight through the synchronizer,
    // the last DEB synchronized views, and the expected outputs.
    bit pipe_q[$];
    bit view_q[$];
    bit m_level, m_rise, m_fall, m_long, m_prev_view;
    int m_hold;

    button_debouncer #(
        .CNT_WIDTH(8), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONGC), .ACTIVE_LOW(1'b0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .btn_raw(raw0),
        .btn_level(lvl0), .btn_rise(rise0), .btn_fall(fall0), .btn_long(long0)
    );

    button_debouncer #(
        .CNT_WIDTH(8), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONGC), .ACTIVE_LOW(1'b1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .btn_raw(raw1),
        .btn_level(lvl1), .btn_rise(rise1), .btn_fall(fall1), .btn_long(long1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        pipe_q.delete();
        pipe_q.push_back(1'b0);
        pipe_q.push_back(1'b0);
        view_q.delete();
        m_level = 0; m_rise = 0; m_fall = 0; m_long = 0;
        m_prev_view = 0; m_hold = 0;
    endtask

    // A level is accepted when the last DEB synchronized views all differ from
    // the current level. Hold time accrues only while the level is high and
    // the input has been seen high on two consecutive views.
    task automatic model_step();
        bit v;
        bit flip;
        if (!rst) begin
            model_reset();
            return;
        end
        v = pipe_q.pop_front();
        pipe_q.push_back(raw0);
        view_q.push_back(v);
        if (view_q.size() > DEB) void'(view_q.pop_front());
        m_rise = 0; m_fall = 0; m_long = 0;
        flip = (view_q.size() == DEB);
        foreach (view_q[i]) if (view_q[i] == m_level) flip = 0;
        if (flip) begin
            m_level = !m_level;
            m_rise  = m_level;
            m_fall  = !m_level;
            m_hold  = 0;
        end else if (m_level && v && m_prev_view) begin
            if (m_hold < LONGC) begin
                m_hold++;
                m_long = (m_hold == LONGC);
            end
        end
        m_prev_view = v;
    endtask

    task automatic tick(input bit r);
        raw0 = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        for (int k = 1; k <= 3; k++) begin
            tick(1'b1);
            total++;
            if ({lvl0, rise0, fall0, long0, lvl1, rise1, fall1, long1} !== 8'h00) begin
                bad++;
                $display("FAIL reset_hold k=%0d got=%b required=00000000", k,
                         {lvl0, rise0, fall0, long0, lvl1, rise1, fall1, long1});
            end
        end
        rst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick(1'b0);
            total++;
            if ({lvl0, rise0, fall0, long0} !== {m_level, m_rise, m_fall, m_long}) begin
                bad++;
                $display("FAIL reset_exit k=%0d got=%b required=%b", k,
                         {lvl0, rise0, fall0, long0}, {m_level, m_rise, m_fall, m_long});
            end
        end
    endtask

    task automatic test_clean_press();
        int rise_at = 0, fall_at = 0, long_at = 0;
        int nr = 0, nf = 0, nl = 0;
        for (int k = 1; k <= 42; k++) begin
            tick(k <= 30);
            total++;
            if ({lvl0, rise0, fall0, long0} !== {m_level, m_rise, m_fall, m_long}) begin
                bad++;
                $display("FAIL clean_press k=%0d got=%b required=%b", k,
                         {lvl0, rise0, fall0, long0}, {m_level, m_rise, m_fall, m_long});
            end
            if (rise0 === 1'b1) begin rise_at = k; nr++; end
            if (fall0 === 1'b1) begin fall_at = k; nf++; end
            if (long0 === 1'b1) begin long_at = k; nl++; end
        end
        total++;
        if (rise_at != 6 || nr != 1) begin
            bad++;
            $display("FAIL clean_rise_edge got edge=%0d count=%0d required edge=6 count=1", rise_at, nr);
        end
        total++;
        if (long_at != 26 || nl != 1) begin
            bad++;
            $display("FAIL clean_long_edge got edge=%0d count=%0d required edge=26 count=1", long_at, nl);
        end
        total++;
        if (fall_at != 36 || nf != 1 || lvl0 !== 1'b0) begin
            bad++;
            $display("FAIL clean_fall_edge got edge=%0d count=%0d lvl=%b required edge=36 count=1 lvl=0",
                     fall_at, nf, lvl0);
        end
    endtask

    task automatic test_bounce();
        bit pat[$];
        pat = '{1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        foreach (pat[k]) begin
            tick(pat[k]);
            total++;
            if ({lvl0, rise0, fall0, long0} !== 4'b0000 ||
                {m_level, m_rise, m_fall, m_long} !== 4'b0000) begin
                bad++;
                $display("FAIL bounce k=%0d got=%b model=%b required=0000", k,
                         {lvl0, rise0, fall0, long0}, {m_level, m_rise, m_fall, m_long});
            end
        end
    endtask

    task automatic test_release_glitch();
        int long_at = 0, fall_at = 0, nf = 0, nr = 0;
        bit r;
        for (int k = 1; k <= 54; k++) begin
            r = (k <= 10) || (k >= 13 && k <= 42);
            tick(r);
            total++;
            if ({lvl0, rise0, fall0, long0} !== {m_level, m_rise, m_fall, m_long}) begin
                bad++;
                $display("FAIL glitch k=%0d got=%b required=%b", k,
                         {lvl0, rise0, fall0, long0}, {m_level, m_rise, m_fall, m_long});
            end
            if (rise0 === 1'b1) nr++;
            if (fall0 === 1'b1) begin fall_at = k; nf++; end
            if (long0 === 1'b1) long_at = k;
        end
        total++;
        if (long_at != 29) begin
            bad++;
            $display("FAIL glitch_long_edge got edge=%0d required edge=29", long_at);
        end
        total++;
        if (nf != 1 || fall_at != 48 || nr != 1) begin
            bad++;
            $display("FAIL glitch_pulses got falls=%0d at %0d rises=%0d required falls=1 at 48 rises=1",
                     nf, fall_at, nr);
        end
    endtask

    task automatic test_reset_mid_press();
        for (int k = 1; k <= 4; k++) tick(1'b1);
        for (int phase = 0; phase < 2; phase++) begin
            rst = 1'b0;
            model_reset();
            #1;
            total++;
            if ({lvl0, rise0, fall0, long0} !== 4'b0000) begin
                bad++;
                $display("FAIL mid_reset_clear phase=%0d got=%b required=0000", phase,
                         {lvl0, rise0, fall0, long0});
            end
            tick(1'b1);
            tick(1'b1);
            total++;
            if ({lvl0, rise0, fall0, long0} !== 4'b0000) begin
                bad++;
                $display("FAIL mid_reset_hold phase=%0d got=%b required=0000", phase,
                         {lvl0, rise0, fall0, long0});
            end
            rst = 1'b1;
            for (int k = 1; k <= 12; k++) begin
                tick(1'b1);
                total++;
                if (rise0 !== (k == 6) || lvl0 !== (k >= 6) || fall0 !== 1'b0 ||
                    {lvl0, rise0, fall0, long0} !== {m_level, m_rise, m_fall, m_long}) begin
                    bad++;
                    $display("FAIL mid_reset_rise phase=%0d k=%0d got=%b model=%b", phase, k,
                             {lvl0, rise0, fall0, long0}, {m_level, m_rise, m_fall, m_long});
                end
            end
        end
        for (int k = 1; k <= 12; k++) begin
            tick(1'b0);
            total++;
            if ({lvl0, rise0, fall0, long0} !== {m_level, m_rise, m_fall, m_long}) begin
                bad++;
                $display("FAIL mid_reset_release k=%0d got=%b required=%b", k,
                         {lvl0, rise0, fall0, long0}, {m_level, m_rise, m_fall, m_long});
            end
        end
    endtask

    task automatic test_polarity();
        for (int k = 1; k <= 22; k++) begin
            raw1 = (k <= 10) ? 1'b0 : 1'b1;
            tick(1'b0);
            total++;
            if (lvl1 !== (k >= 6 && k < 16) || rise1 !== (k == 6) ||
                fall1 !== (k == 16) || long1 !== 1'b0) begin
                bad++;
                $display("FAIL polarity k=%0d got lvl/rise/fall/long=%b required=%b", k,
                         {lvl1, rise1, fall1, long1},
                         {(k >= 6 && k < 16), (k == 6), (k == 16), 1'b0});
            end
        end
    endtask

    task automatic test_random();
        bit val = 0;
        bit expect_rise = 1;
        int len;
        for (int r = 0; r < 40; r++) begin
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 6);
            val = !val;
            if (r == 39) begin
                val = 0;
                len = 12;
            end
            for (int j = 0; j < len; j++) begin
                tick(val);
                total++;
                if ({lvl0, rise0, fall0, long0} !== {m_level, m_rise, m_fall, m_long}) begin
                    bad++;
                    $display("FAIL random r=%0d j=%0d got=%b required=%b", r, j,
                             {lvl0, rise0, fall0, long0}, {m_level, m_rise, m_fall, m_long});
                end
                if (rise0 === 1'b1) begin
                    total++;
                    if (!expect_rise) begin
                        bad++;
                        $display("FAIL random_order r=%0d got=rise required=fall", r);
                    end
                    expect_rise = 0;
                end
                if (fall0 === 1'b1) begin
                    total++;
                    if (expect_rise) begin
                        bad++;
                        $display("FAIL random_order r=%0d got=fall required=rise", r);
                    end
                    expect_rise = 1;
                end
            end
        end
    endtask

    task automatic test_downstream();
        bit seq[$];
        bit q = 0, prev = 0;
        int changes = 0;
        rst = 1'b0;
        model_reset();
        tick(1'b0);
        rst = 1'b1;
        for (int p = 0; p < 3; p++) begin
            seq.push_back(1); seq.push_back(0); seq.push_back(1); seq.push_back(0);
            for (int j = 0; j < 10; j++) seq.push_back(1);
            seq.push_back(0); seq.push_back(1); seq.push_back(0); seq.push_back(1);
            for (int j = 0; j < 10; j++) seq.push_back(0);
        end
        foreach (seq[k]) begin
            tick(seq[k]);
            total++;
            if ({lvl0, rise0, fall0, long0} !== {m_level, m_rise, m_fall, m_long}) begin
                bad++;
                $display("FAIL downstream k=%0d got=%b required=%b", k,
                         {lvl0, rise0, fall0, long0}, {m_level, m_rise, m_fall, m_long});
            end
            // Edge-triggered toggle stage fed from btn_level on its T input
            if (lvl0 === 1'b1 && !prev) begin
                q = !q;
                changes++;
            end
            prev = (lvl0 === 1'b1);
        end
        total++;
        if (changes != 3 || q != 1'b1) begin
            bad++;
            $display("FAIL toggle_stage got changes=%0d q=%b required changes=3 q=1", changes, q);
        end
    endtask

    initial begin
        rst  = 1'b0;
        raw0 = 1'b0;
        raw1 = 1'b1;
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_glitch();
        test_reset_mid_press();
        test_polarity();
        test_random();
        test_downstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
